mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Bus initiator that drives the single-port byte-enabled data RAM on behalf of the CPU load/store path. It accepts one byte/half/word load or store request and checks alignment. It generates the word address, byte-write mask and lane-shifted write data, then extracts and sign/zero-extends load data from the RAM's 1-cycle registered read port. It sits between the core's execute stage and the data RAM instance.

Parameters:
ADDR_WIDTH, 32, width of the byte address from the core
RAM_ADDR_WIDTH, 14, word-address width of the attached RAM (16384 words)
DATA_WIDTH, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_error  out  1  misaligned or illegal size; qualified by resp_valid
resp_rdata  out  32  extended load data; 0 for stores and errors
ram_we  out  4  byte write enables to RAM
ram_addr  out  RAM_ADDR_WIDTH  word address to RAM
ram_data  out  32  lane-positioned write data
ram_q  in  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Clock/reset: one clock `clk`; synchronous active-high `reset`.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, ram_we=0, ram_addr=0, ram_data=0.
- FSM states and outputs:
  - IDLE: req_ready=1.
  - ACCESS: req_ready=0.
  - RESP: req_ready=0.
- Handshake: a request is accepted at cycle T when req_valid && req_ready. At acceptance, latch write, size, unsigned, addr[1:0].
- Alignment error:
  - Conditions: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or size=11.
  - Action: IDLE→RESP at T+1 with resp_valid=1, resp_error=1, resp_rdata=0. No RAM access; ram_we stays 0.
- Legal request: IDLE→ACCESS at T+1 (registered outputs).
  - ram_addr = req_addr[RAM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so the address wraps modulo RAM size.
  - ram_we (store): byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
  - ram_we (load): 0000.
  - ram_data: byte = wdata[7:0] replicated ×4; half = wdata[15:0] replicated ×2; word = wdata.
- ACCESS→RESP at T+2:
  - ram_we returns to 0; ram_we is high for exactly one cycle per store.
  - ram_addr and ram_data are held.
  - resp_valid=1, resp_error=0.
- Load data in RESP: resp_rdata is derived combinationally from ram_q.
  - Byte lane: addr[1:0]. Half lane: addr[1].
  - Sign-extend from bit 7/15 unless unsigned=1.
  - Word passes ram_q unchanged.
- Store response in RESP: resp_rdata=0.
- RESP→IDLE always. resp_valid, resp_error and resp_rdata are 0 outside RESP.
- Throughput: one transaction per 3 cycles (2 for errors). req_valid while req_ready=0 is ignored; the request must be held by the core.
- Reset mid-transaction: the pending operation is abandoned, no response is issued, and ram_we is forced to 0 at the reset edge. A store is either fully written in ACCESS or not at all.
- Request fields are not sampled outside the acceptance cycle.

Test Plan:
- Store word addr=0x100 data=0xDEADBEEF → T+1: ram_addr=0x040, ram_we=1111, ram_data=0xDEADBEEF for 1 cycle; T+2: resp_valid=1, resp_error=0, resp_rdata=0.
- Store byte addr=0x103 data=0x000000A5 → ram_we=1000, ram_data=0xA5A5A5A5. Then load word 0x100 → resp_rdata=0xA5ADBEEF at T+2.
- Loads from word 0x100 = 0x80FF7F01:
  - signed byte addr=0x102 → 0xFFFFFFFF
  - unsigned byte addr=0x102 → 0x000000FF
  - signed half addr=0x102 → 0xFFFF80FF
  - unsigned half addr=0x100 → 0x00007F01
- Misaligned half addr=0x101, word addr=0x102, and size=11 → each: resp_valid=1, resp_error=1 at T+1; ram_we never asserted; RAM contents unchanged.
- Back-to-back req_valid held high → req_ready low in ACCESS/RESP; second request accepted only in the cycle after RESP; each request gets exactly one resp_valid pulse.
- Assert reset during ACCESS of a store → ram_we=0 after the edge; no resp_valid; all outputs at reset values; req_ready=1 next cycle.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side signal bundle for mem_access_unit.
// Latency: none (wiring only).
// Backpressure: req_ready qualifies req_valid; the RAM side has no backpressure.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 14
);
    // core request
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_size;
    logic                      req_unsigned;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [31:0]               req_wdata;
    // core response
    logic                      resp_valid;
    logic                      resp_error;
    logic [31:0]               resp_rdata;
    // data RAM port
    logic [3:0]                ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]               ram_data;
    logic [31:0]               ram_q;

    // master: the surroundings (execute stage plus data RAM) seen from outside the unit
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_q,
        input  req_ready, resp_valid, resp_error, resp_rdata, ram_we, ram_addr, ram_data
    );

    // slave: the access unit itself
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_q,
        output req_ready, resp_valid, resp_error, resp_rdata, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-enabled single-port RAM with alignment checking.
// Latency: legal access responds 2 cycles after acceptance, misaligned/illegal after 1.
// Backpressure: req_ready only in IDLE; one transaction in flight, requester holds its request.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH     = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, state_nxt;
    logic                   wr_q, uns_q, err_q;
    logic [1:0]             size_q, lane_q;
    logic                   accept, misaligned;
    logic [3:0]             we_nxt;
    logic [DATA_WIDTH-1:0]  data_nxt, load_data;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic                   unused_addr_bits;

    // the RAM is word addressed and smaller than the byte address space; high bits wrap
    assign unused_addr_bits = ^bus.req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2];
    assign accept = bus.req_valid && bus.req_ready;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and handshake/response strobes
    always_comb begin
        state_nxt       = state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_error  = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = misaligned ? RESP : ACCESS;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // alignment check plus byte-enable and lane-replicated write data for the new request
    always_comb begin
        misaligned = 1'b0;
        we_nxt     = 4'b0000;
        data_nxt   = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                we_nxt   = 4'b0001 << bus.req_addr[1:0];
                data_nxt = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = bus.req_addr[0];
                we_nxt     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                data_nxt   = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = (bus.req_addr[1:0] != 2'b00);
                we_nxt     = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // latch request attributes and drive the RAM; write enable is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q         <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            bus.ram_we   <= 4'b0000;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
        end else begin
            bus.ram_we <= 4'b0000;
            if (accept) begin
                wr_q   <= bus.req_write;
                uns_q  <= bus.req_unsigned;
                err_q  <= misaligned;
                size_q <= bus.req_size;
                lane_q <= bus.req_addr[1:0];
                if (!misaligned) begin
                    bus.ram_addr <= bus.req_addr[RAM_ADDR_WIDTH+1:2];
                    bus.ram_data <= data_nxt;
                    bus.ram_we   <= bus.req_write ? we_nxt : 4'b0000;
                end
            end
        end
    end

    // pick the addressed lane out of the registered RAM output and extend it
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = bus.ram_q;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    byte_sel = bus.ram_q[7:0];
                    2'd1:    byte_sel = bus.ram_q[15:8];
                    2'd2:    byte_sel = bus.ram_q[23:16];
                    default: byte_sel = bus.ram_q[31:24];
                endcase
                load_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                half_sel  = lane_q[1] ? bus.ram_q[31:16] : bus.ram_q[15:0];
                load_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            end
            default: load_data = bus.ram_q;
        endcase
    end

    assign bus.resp_rdata = (state == RESP && !err_q && !wr_q) ? load_data : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_init = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(14)) bus();

    mem_access_unit #(.ADDR_WIDTH(32), .RAM_ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        rv;
        logic        re;
        logic [31:0] rd;
        logic [3:0]  we;
        logic        rdy;
    } stage_t;

    typedef struct packed {
        logic   rdy0;
        stage_t s1;
        stage_t s2;
        stage_t s3;
    } ctl_t;

    typedef struct packed {
        logic [13:0] a1;
        logic [13:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
    } ramv_t;

    typedef struct packed {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  lit_we;
        logic [31:0] lit_val;
    } dir_t;

    logic [31:0] ram [16384];
    logic [7:0]  ref_mem [65536];

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // word-wide RAM with registered read, as seen by the unit
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16384; i++) ram[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_data[8*b +: 8];
            bus.ram_q <= ram[bus.ram_addr];
        end
    end

    function automatic stage_t sample();
        stage_t s;
        s.rv  = bus.resp_valid;
        s.re  = bus.resp_error;
        s.rd  = bus.resp_rdata;
        s.we  = bus.ram_we;
        s.rdy = bus.req_ready;
        return s;
    endfunction

    // byte-addressed reference: expected cycle-by-cycle view of one isolated transaction
    task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output ctl_t c, output ramv_t r, output logic err);
        int n, ba;
        logic [31:0] v;
        c = '0;
        r = '0;
        c.rdy0   = 1'b1;
        c.s3.rdy = 1'b1;
        err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        if (err) begin
            c.s1.rv  = 1'b1;
            c.s1.re  = 1'b1;
            c.s2.rdy = 1'b1;
            return;
        end
        n  = 1 << sz;
        ba = int'(a[15:0]);
        r.a1 = a[15:2];
        r.a2 = a[15:2];
        for (int k = 0; k < 4; k++) r.d1[8*k +: 8] = wd[8*(k % n) +: 8];
        r.d2 = r.d1;
        c.s2.rv = 1'b1;
        if (w) begin
            for (int k = 0; k < n; k++) begin
                ref_mem[ba + k] = wd[8*k +: 8];
                c.s1.we[(ba % 4) + k] = 1'b1;
            end
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[ba + k]) << (8 * k));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            c.s2.rd = v;
        end
    endtask

    // drive one request, then record three cycles of response-side behaviour
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output ctl_t c, output ramv_t r);
        @(negedge clk);
        c.rdy0 = bus.req_ready;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        @(negedge clk);
        c.s1 = sample();
        r.a1 = bus.ram_addr;
        r.d1 = bus.ram_data;
        @(negedge clk);
        c.s2 = sample();
        r.a2 = bus.ram_addr;
        r.d2 = bus.ram_data;
        @(negedge clk);
        c.s3 = sample();
    endtask

    task automatic test_reset();
        ram_init = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 ram_init = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else passed++;
        total++; if (bus.resp_error !== 1'b0) $display("FAIL reset_resp_error got %b want 0", bus.resp_error); else passed++;
        total++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", bus.resp_rdata); else passed++;
        total++; if (bus.ram_we !== 4'h0) $display("FAIL reset_ram_we got %b want 0000", bus.ram_we); else passed++;
        total++; if (bus.ram_addr !== 14'h0) $display("FAIL reset_ram_addr got %h want 0", bus.ram_addr); else passed++;
        total++; if (bus.ram_data !== 32'h0) $display("FAIL reset_ram_data got %h want 0", bus.ram_data); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        dir_t tbl [7];
        ctl_t c, ce;
        ramv_t r, re;
        logic err;
        tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5};
        tbl[2] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hA5ADBEEF};
        tbl[3] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF7F01, 4'b1111, 32'h80FF7F01};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h102, 32'h0,        4'b0000, 32'hFFFFFFFF};
        tbl[5] = '{1'b0, 2'd0, 1'b1, 32'h102, 32'h0,        4'b0000, 32'h000000FF};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        4'b0000, 32'hFFFF80FF};
        for (int i = 0; i < 7; i++) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, ce, re, err);
            issue(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, c, r);
            total++; if (c !== ce) $display("FAIL dir_ctl[%0d] got %h want %h", i, c, ce); else passed++;
            total++; if (r !== re) $display("FAIL dir_ram[%0d] got %h want %h", i, r, re); else passed++;
            if (tbl[i].w) begin
                total++; if (c.s1.we !== tbl[i].lit_we || r.d1 !== tbl[i].lit_val || r.a1 !== 14'h040)
                    $display("FAIL dir_store[%0d] got we=%b data=%h addr=%h want we=%b data=%h addr=040",
                             i, c.s1.we, r.d1, r.a1, tbl[i].lit_we, tbl[i].lit_val); else passed++;
            end else begin
                total++; if (c.s2.rd !== tbl[i].lit_val)
                    $display("FAIL dir_load[%0d] got %h want %h", i, c.s2.rd, tbl[i].lit_val); else passed++;
            end
        end
        issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, c, r);
        total++; if (c.s2.rd !== 32'h00007F01) $display("FAIL dir_load_uhalf got %h want 00007f01", c.s2.rd); else passed++;
    endtask

    task automatic test_misaligned();
        logic [1:0]  szs [3];
        logic [31:0] ads [3];
        ctl_t c, ce;
        ramv_t r, re;
        logic err;
        szs = '{2'd1, 2'd2, 2'd3};
        ads = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            model(1'b1, szs[i], 1'b0, ads[i], 32'h11223344, ce, re, err);
            issue(1'b1, szs[i], 1'b0, ads[i], 32'h11223344, c, r);
            total++; if (c !== ce) $display("FAIL misalign_ctl[%0d] got %h want %h", i, c, ce); else passed++;
            total++; if (c.s1.rv !== 1'b1 || c.s1.re !== 1'b1 || (c.s1.we | c.s2.we | c.s3.we) !== 4'h0)
                $display("FAIL misalign_resp[%0d] got rv=%b re=%b we=%b want rv=1 re=1 we=0000",
                         i, c.s1.rv, c.s1.re, c.s1.we | c.s2.we | c.s3.we); else passed++;
        end
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, c, r);
        total++; if (c.s2.rd !== 32'h80FF7F01) $display("FAIL misalign_ram_kept got %h want 80ff7f01", c.s2.rd); else passed++;
    endtask

    task automatic test_random();
        ctl_t c, ce;
        ramv_t r, re;
        logic err, w, uns;
        logic [1:0] sz;
        logic [15:0] lo;
        logic [31:0] a, wd;
        int k;
        for (int i = 0; i < 400; i++) begin
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            sz  = (k < 3) ? 2'd0 : (k < 6) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
            wd  = $urandom;
            lo  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0200 + 16'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) lo[0] = 1'b0;
                if (sz == 2'd2) lo[1:0] = 2'b00;
            end
            a = {16'($urandom), lo};
            model(w, sz, uns, a, wd, ce, re, err);
            issue(w, sz, uns, a, wd, c, r);
            total++; if (c !== ce) $display("FAIL rand_ctl[%0d] a=%h sz=%0d w=%b got %h want %h", i, a, sz, w, c, ce); else passed++;
            if (!err) begin
                total++; if (r !== re) $display("FAIL rand_ram[%0d] a=%h got %h want %h", i, a, r, re); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  szs [3];
        logic        unss [3];
        logic [31:0] ads [3];
        logic [31:0] exp_rd [3];
        int acc_cyc [3];
        int rsp_cyc [3];
        int acc_n, rsp_n, idx;
        logic rdy;
        ctl_t ce;
        ramv_t re;
        logic err;
        szs  = '{2'd2, 2'd1, 2'd0};
        unss = '{1'b0, 1'b1, 1'b0};
        ads  = '{32'h0000_0100, 32'hFFFF_0102, 32'h0001_0103};
        for (int i = 0; i < 3; i++) begin
            model(1'b0, szs[i], unss[i], ads[i], 32'h0, ce, re, err);
            exp_rd[i] = ce.s2.rd;
        end
        acc_n = 0;
        rsp_n = 0;
        idx   = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_wdata = $urandom;
        bus.req_size = szs[0]; bus.req_unsigned = unss[0]; bus.req_addr = ads[0];
        for (int cyc = 0; cyc < 14; cyc++) begin
            rdy = bus.req_ready;
            if (bus.resp_valid === 1'b1) begin
                if (rsp_n < 3) begin
                    rsp_cyc[rsp_n] = cyc;
                    total++; if (bus.resp_rdata !== exp_rd[rsp_n] || bus.resp_error !== 1'b0)
                        $display("FAIL b2b_rdata[%0d] got %h err=%b want %h err=0", rsp_n, bus.resp_rdata, bus.resp_error, exp_rd[rsp_n]);
                    else passed++;
                end
                rsp_n++;
            end
            if (rdy === 1'b1 && bus.req_valid) begin
                if (acc_n < 3) acc_cyc[acc_n] = cyc;
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (rdy === 1'b1 && bus.req_valid) begin
                idx++;
                if (idx < 3) begin
                    bus.req_size = szs[idx]; bus.req_unsigned = unss[idx]; bus.req_addr = ads[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        total++; if (acc_n !== 3) $display("FAIL b2b_accepts got %0d want 3", acc_n); else passed++;
        total++; if (rsp_n !== 3) $display("FAIL b2b_responses got %0d want 3", rsp_n); else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < acc_n) begin
                total++; if (acc_cyc[i] !== 3 * i) $display("FAIL b2b_accept_cycle[%0d] got %0d want %0d", i, acc_cyc[i], 3 * i); else passed++;
            end
            if (i < rsp_n) begin
                total++; if (rsp_cyc[i] !== 3 * i + 2) $display("FAIL b2b_resp_cycle[%0d] got %0d want %0d", i, rsp_cyc[i], 3 * i + 2); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        ctl_t c, ce;
        ramv_t r, re;
        logic err;
        // the store is already on the RAM port when reset hits, so it lands in full
        model(1'b1, 2'd2, 1'b0, 32'h300, 32'hC0FFEE42, ce, re, err);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h300; bus.req_wdata = 32'hC0FFEE42;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.ram_we !== 4'hF) $display("FAIL midrst_access_we got %b want 1111", bus.ram_we); else passed++;
        @(negedge clk);
        total++; if (bus.ram_we !== 4'h0) $display("FAIL midrst_we got %b want 0000", bus.ram_we); else passed++;
        total++; if (bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0 || bus.resp_rdata !== 32'h0)
            $display("FAIL midrst_resp got rv=%b re=%b rd=%h want 0 0 0", bus.resp_valid, bus.resp_error, bus.resp_rdata); else passed++;
        total++; if (bus.ram_addr !== 14'h0 || bus.ram_data !== 32'h0)
            $display("FAIL midrst_ram got addr=%h data=%h want 0 0", bus.ram_addr, bus.ram_data); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
            $display("FAIL midrst_after got rdy=%b rv=%b want rdy=1 rv=0", bus.req_ready, bus.resp_valid); else passed++;
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, c, r);
        total++; if (c.s2.rd !== 32'hC0FFEE42) $display("FAIL midrst_stored got %h want c0ffee42", c.s2.rd); else passed++;
    endtask

    initial begin
        logic [31:0] w;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        for (int i = 0; i < 16384; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        test_reset();
        test_directed();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
